// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
// ---------------
// Collects command frames from the UART receiver byte stream and hands each
// complete frame to the SPI master top in one atomic update.
//
// Frame layout on the wire:
//   SYNC_BYTE, cmd, addrLsb, addrMsb, dataLsb, dataMsb [, xor checksum]
// The checksum byte exists only when CMD_CHECKSUM_EN is defined. It is the
// XOR of the five payload bytes.
//
// Ports:
//   clk40M       40 MHz system clock
//   nRst         asynchronous, active-low reset
//   rx_dv        one-cycle strobe: rx_byte is valid
//   rx_byte      received UART byte
//   cmdUpdate    one-cycle pulse: a new frame is on the o_* outputs
//   o_cmd        payload[0]
//   o_addrLsb    payload[1]
//   o_addrMsb    payload[2]
//   o_dataLsb    payload[3]
//   o_dataMsb    payload[4]
//   frame_err    one-cycle pulse: a frame was discarded (timeout / bad checksum)
//   err_count    saturating count of discarded frames (cleared by reset only)
//   busy         high while a frame is being collected (state != HUNT)
//   dbg_state_o  current FSM state encoding, for checkers
//
// Handshake: a byte is accepted on any rising clk40M edge where rx_dv is high.
// There is no backpressure in either direction. cmdUpdate and frame_err are
// single-cycle strobes, and the o_* bytes hold their values until the next
// cmdUpdate.
module uart_cmd_framer #(
  parameter logic [7:0] SYNC_BYTE     = 8'hAA,
  parameter int         PAYLOAD_BYTES = 5,
  parameter int         TIMEOUT_CLKS  = 40000
) (
  input  logic       clk40M,
  input  logic       nRst,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       cmdUpdate,
  output logic [7:0] o_cmd,
  output logic [7:0] o_addrLsb,
  output logic [7:0] o_addrMsb,
  output logic [7:0] o_dataLsb,
  output logic [7:0] o_dataMsb,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]      LAST_IDX = 3'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
`ifdef CMD_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    COMMIT  = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] tmo_q;
  logic [7:0]       shadow_q [PAYLOAD_BYTES];
  logic [7:0]       cmd_q, addr_lsb_q, addr_msb_q, data_lsb_q, data_msb_q;
  logic             cmd_update_q, frame_err_q, busy_q;
  logic [7:0]       err_count_q;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] csum_d;
  assign csum_d = shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3] ^ shadow_q[4];
`endif

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      tmo_q        <= '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) shadow_q[i] <= '0;
      cmd_q        <= '0;
      addr_lsb_q   <= '0;
      addr_msb_q   <= '0;
      data_lsb_q   <= '0;
      data_msb_q   <= '0;
      cmd_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      cmd_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        // COMMIT publishes the frame and then behaves exactly like HUNT, so a
        // sync byte arriving in the commit cycle starts the next frame.
        HUNT, COMMIT: begin
          if (state_q == COMMIT) begin
            cmd_q        <= shadow_q[0];
            addr_lsb_q   <= shadow_q[1];
            addr_msb_q   <= shadow_q[2];
            data_lsb_q   <= shadow_q[3];
            data_msb_q   <= shadow_q[4];
            cmd_update_q <= 1'b1;
          end
          tmo_q <= '0;
          idx_q <= '0;
          if (rx_dv && (rx_byte == SYNC_BYTE)) begin
            state_q <= PAYLOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        end
        // Sync-valued bytes here are payload data; no resynchronisation.
        PAYLOAD: begin
          if (rx_dv) begin
            shadow_q[idx_q] <= rx_byte;
            tmo_q           <= '0;
            if (idx_q == LAST_IDX) begin
`ifdef CMD_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q <= COMMIT;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= HUNT;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
`ifdef CMD_CHECKSUM_EN
        CHECK: begin
          if (rx_dv) begin
            tmo_q <= '0;
            if (rx_byte == csum_d) begin
              state_q <= COMMIT;
            end else begin
              state_q     <= HUNT;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= HUNT;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= HUNT;
          busy_q  <= 1'b0;
          tmo_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign cmdUpdate   = cmd_update_q;
  assign o_cmd       = cmd_q;
  assign o_addrLsb   = addr_lsb_q;
  assign o_addrMsb   = addr_msb_q;
  assign o_dataLsb   = data_lsb_q;
  assign o_dataMsb   = data_msb_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
